// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline sequencing controller for the ID/EX stage register and the stages
// around it. Each cycle it decides whether the front end advances, stalls for
// one cycle (load-use bubble), is flushed (taken branch), or is frozen while a
// multi-cycle EX operation completes.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined   -> 32-bit wrapping stall_cycles / flush_count counters exist
//   undefined -> both counter ports are tied to 0 and no counter flops exist
//
// Parameters:
//   MC_LATENCY      total EX-occupancy cycles of a multi-cycle op (1..16)
//
// Ports:
//   clk             pipeline clock, rising edge
//   rst             asynchronous active-high reset
//   id_rs1/id_rs2   source register fields of the instruction in ID
//   id_uses_rs1/2   the ID instruction actually reads that source
//   ex_rd           destination register of the instruction in EX
//   ex_MemRead      the EX instruction is a load
//   ex_branch_taken branch resolved taken in EX this cycle
//   ex_mc_start     the EX instruction is multi-cycle (sampled in RUN only)
//   pc_write        PC load enable
//   if_id_write     IF/ID load enable
//   if_id_flush     IF/ID clears to a NOP at the next edge (wins over write)
//   id_ex_bubble    ID/EX loads zeroed control bits at the next edge
//   id_ex_hold      ID/EX retains its contents
//   ex_busy         a multi-cycle operation is occupying EX
//   stall_cycles    non-reset cycles with pc_write=0 (perf counter)
//   flush_count     accepted taken branches (perf counter)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int unsigned MC_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_MemRead,
    input  logic        ex_branch_taken,
    input  logic        ex_mc_start,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        id_ex_hold,
    output logic        ex_busy,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_t;

    // A latency of 1 means the op finishes in its start cycle, so it is
    // handled exactly like an ordinary instruction.
    localparam bit         MC_EN     = (MC_LATENCY > 1);
    // The start cycle and the final release cycle are not counted in cnt,
    // hence the reload value of MC_LATENCY-2.
    localparam logic [3:0] MC_RELOAD = (MC_LATENCY > 1) ? 4'(MC_LATENCY - 2) : 4'd0;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;

    logic       w_lu;
    logic       w_pc_write;
    logic       w_if_id_write;
    logic       w_if_id_flush;
    logic       w_id_ex_bubble;
    logic       w_id_ex_hold;
    logic       w_ex_busy;

    // x0 is hard-wired to zero, so a load into x0 never creates a hazard.
    assign w_lu = ex_MemRead && (ex_rd != 5'd0) &&
                  ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                   (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_pc_write     = 1'b1;
        w_if_id_write  = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_bubble = 1'b0;
        w_id_ex_hold   = 1'b0;
        w_ex_busy      = 1'b0;
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;

        case (r_state)
            RUN: begin
                // Priority: branch squash > multi-cycle start > load-use.
                if (ex_branch_taken) begin
                    w_if_id_flush  = 1'b1;
                    w_id_ex_bubble = 1'b1;
                end else if (ex_mc_start && MC_EN) begin
                    w_pc_write    = 1'b0;
                    w_if_id_write = 1'b0;
                    w_id_ex_hold  = 1'b1;
                    w_ex_busy     = 1'b1;
                    w_state_nxt   = MC_BUSY;
                    w_cnt_nxt     = MC_RELOAD;
                end else if (w_lu) begin
                    // The bubble removes the hazard, so the same ID
                    // instruction proceeds on the following cycle.
                    w_pc_write     = 1'b0;
                    w_if_id_write  = 1'b0;
                    w_id_ex_bubble = 1'b1;
                end
            end
            MC_BUSY: begin
                // Branch, new mc start and load-use are all ignored here.
                w_ex_busy = 1'b1;
                if (r_cnt != 4'd0) begin
                    w_pc_write    = 1'b0;
                    w_if_id_write = 1'b0;
                    w_id_ex_hold  = 1'b1;
                    w_cnt_nxt     = r_cnt - 4'd1;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_cnt_nxt   = 4'd0;
            end
        endcase

        // Reset forces a flushed, frozen front end regardless of state.
        if (rst) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_if_id_flush  = 1'b1;
            w_id_ex_bubble = 1'b1;
            w_id_ex_hold   = 1'b0;
            w_ex_busy      = 1'b0;
        end
    end

    assign pc_write     = w_pc_write;
    assign if_id_write  = w_if_id_write;
    assign if_id_flush  = w_if_id_flush;
    assign id_ex_bubble = w_id_ex_bubble;
    assign id_ex_hold   = w_id_ex_hold;
    assign ex_busy      = w_ex_busy;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;
    logic        w_branch_acc;

    // Branches seen in MC_BUSY are ignored, so they are not counted.
    assign w_branch_acc = (r_state == RUN) && ex_branch_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 32'd0;
        end else begin
            if (!w_pc_write) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_branch_acc) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2;
    logic        ex_MemRead, ex_branch_taken, ex_mc_start;
    logic        pc_write, if_id_write, if_id_flush;
    logic        id_ex_bubble, id_ex_hold, ex_busy;
    logic [31:0] stall_cycles, flush_count;
    logic [5:0]  ctl;

    int n_vec = 0;
    int n_err = 0;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.MC_LATENCY(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd           (ex_rd),
        .ex_MemRead      (ex_MemRead),
        .ex_branch_taken (ex_branch_taken),
        .ex_mc_start     (ex_mc_start),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .id_ex_hold      (id_ex_hold),
        .ex_busy         (ex_busy),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    // {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_busy}
    assign ctl = {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_busy};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle: after the rising edge, apply inputs, then check outputs.
    task automatic step(input string tag, input logic mr, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic br, input logic mc, input logic [5:0] exp);
        @(posedge clk);
        #1;
        ex_MemRead      = mr;
        ex_rd           = rd;
        id_rs1          = rs1;
        id_uses_rs1     = u1;
        id_rs2          = rs2;
        id_uses_rs2     = u2;
        ex_branch_taken = br;
        ex_mc_start     = mc;
        #1;
        chk(tag, {26'd0, ctl}, {26'd0, exp});
    endtask

    initial begin
        rst = 1'b1;
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_MemRead = 1'b0; ex_branch_taken = 1'b0; ex_mc_start = 1'b0;
        #2;
        chk("reset_ctl",   {26'd0, ctl}, {26'd0, 6'b001100});
        chk("reset_stall", stall_cycles, 32'd0);
        chk("reset_flush", flush_count,  32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        //            tag            mr    rd     rs1  u1    rs2  u2    br    mc    exp
        step("idle",          1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b110000);
        step("lu_rs1",        1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 6'b000100);
        step("lu_resolved",   1'b0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 6'b110000);
        chk("stall_after_lu", stall_cycles, PERF ? 32'd1 : 32'd0);
        step("lu_rd0",        1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 6'b110000);
        step("lu_no_use",     1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b110000);
        step("lu_rs2",        1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 6'b000100);
        step("br_over_lu",    1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 6'b111100);
        chk("stall_after_rs2", stall_cycles, PERF ? 32'd2 : 32'd0);
        step("after_br",      1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b110000);
        chk("flush_after_br", flush_count, PERF ? 32'd1 : 32'd0);

        // Multi-cycle op overriding load-use; branches during MC_BUSY ignored.
        step("mc_start",      1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 6'b000011);
        step("mc_busy_br2",   1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 6'b000011);
        step("mc_busy_br1",   1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 6'b000011);
        step("mc_release_br", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 6'b110001);
        step("mc_after",      1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b110000);
        chk("stall_after_mc", stall_cycles, PERF ? 32'd5 : 32'd0);
        chk("flush_after_mc", flush_count,  PERF ? 32'd1 : 32'd0);

        // Back-to-back multi-cycle ops with mc_start held high.
        step("b2b_start1",    1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'b000011);
        step("b2b_busy2",     1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'b000011);
        step("b2b_busy1",     1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'b000011);
        step("b2b_release",   1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'b110001);
        step("b2b_start2",    1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'b000011);
        step("b2b2_busy2",    1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b000011);
        step("b2b2_busy1",    1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b000011);
        chk("stall_before_rst", stall_cycles, PERF ? 32'd10 : 32'd0);

        // Asynchronous reset while cnt=1 in MC_BUSY, mid-cycle.
        rst = 1'b1;
        #1;
        chk("async_rst_ctl",   {26'd0, ctl}, {26'd0, 6'b001100});
        chk("async_rst_stall", stall_cycles, 32'd0);
        chk("async_rst_flush", flush_count,  32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        step("post_rst_idle", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b110000);
        step("re_start",      1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'b000011);
        step("re_busy2",      1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b000011);
        step("re_busy1",      1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b000011);
        step("re_release",    1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b110001);
        step("re_after",      1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b110000);
        chk("stall_after_re", stall_cycles, PERF ? 32'd3 : 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Pipeline sequencing controller for the ID/EX stage register and its neighbours.
- Decides each cycle whether the front end advances, stalls, or is flushed:
  - load-use hazards insert a bubble,
  - taken branches squash the wrong-path instructions,
  - multi-cycle EX operations freeze the front end with a latency counter.
- Sits beside the decode stage: it reads decode register fields and ID/EX control outputs, and drives PC, IF/ID and ID/EX write/flush controls.

## Interface
- MC_LATENCY, 4: total EX-occupancy cycles of a multi-cycle operation; legal range 1..16.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs1, id_rs2  in  5 each  source register fields of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction reads that source.
- ex_rd  in  5  destination of the instruction in EX (ID/EX output).
- ex_MemRead  in  1  the EX instruction is a load.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- ex_mc_start  in  1  the EX instruction is multi-cycle; sampled only in RUN.
- pc_write  out  1  PC register load enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID clears to a NOP at the next edge.
- id_ex_bubble  out  1  ID/EX loads zeroed control bits (ALUSrc..RegWrite, ALUOp) at the next edge.
- id_ex_hold  out  1  ID/EX retains its contents.
- ex_busy  out  1  a multi-cycle operation is in flight.
- stall_cycles  out  32  count of stall cycles (see Configuration).
- flush_count  out  32  count of branch flushes (see Configuration).

## Operation
- States: RUN, MC_BUSY. A 4-bit down-counter `cnt` is used in MC_BUSY.
- Reset: state=RUN, cnt=0, counters=0.
- Outputs are combinational from state, cnt and inputs.
  - While rst=1: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, id_ex_hold=0, ex_busy=0.
- Load-use hazard, `lu`: ex_MemRead && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
- RUN, evaluated in priority order:
  1. ex_branch_taken: pc_write=1, if_id_flush=1, id_ex_bubble=1; stay in RUN. Overrides `lu` and ex_mc_start.
  2. ex_mc_start with MC_LATENCY>1: pc_write=0, if_id_write=0, id_ex_hold=1, ex_busy=1; cnt<=MC_LATENCY-2; go to MC_BUSY. Overrides `lu`.
  3. `lu`: pc_write=0, if_id_write=0, id_ex_bubble=1; stay in RUN. Exactly one bubble per hazard.
  4. Otherwise: pc_write=1, if_id_write=1, all other outputs 0.
- ex_mc_start with MC_LATENCY==1 is treated as a normal instruction.
- MC_BUSY: ex_busy=1.
  - cnt!=0: pc_write=0, if_id_write=0, id_ex_hold=1; cnt<=cnt-1.
  - cnt==0: release with pc_write=1, if_id_write=1, hold=0; go to RUN.
  - ex_branch_taken, ex_mc_start and `lu` are ignored throughout MC_BUSY.
- id_ex_bubble and id_ex_hold are never both 1.
- if_id_flush and if_id_write may both be 1; flush wins at IF/ID.

## Timing
- Load-use: exactly 1 stall cycle. The dependent instruction re-evaluates next cycle against the bubble and proceeds.
- Branch: 0 extra cycles beyond the flush. Two instructions are squashed (IF/ID and the ID instruction).
- Multi-cycle op occupies EX for exactly MC_LATENCY cycles: start cycle plus MC_LATENCY-1 MC_BUSY cycles. The front end stalls for MC_LATENCY-1 cycles.
- Reset assertion mid-MC_BUSY returns to RUN immediately and asynchronously. The counter is cleared.
- Back-to-back multi-cycle ops: the second is seen in RUN on the cycle after release and restarts the sequence with no gap.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cycles increments on every non-reset cycle with pc_write=0.
  - flush_count increments on every accepted ex_branch_taken in RUN.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and reset to 0.
- Not defined: both ports are tied to 0 and no counter flops exist.

## Test plan
- Load x5 in EX (ex_MemRead=1, ex_rd=5), ID reads rs1=5 -> one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1, then normal.
- Same with ex_rd=0, or with id_uses_rs1=0 -> no stall.
- ex_branch_taken=1 together with `lu` -> if_id_flush=1, id_ex_bubble=1, pc_write=1; flush_count +1 with the macro.
- MC_LATENCY=4, ex_mc_start pulse -> ex_busy=1 for 4 cycles; id_ex_hold=1 for the first 3; pc_write returns to 1 on the 4th; stall_cycles +3.
- ex_branch_taken asserted during MC_BUSY -> ignored, no flush.
- rst asserted at MC_BUSY cnt=1 -> immediate RUN with reset outputs. After release, ex_mc_start restarts the full 4-cycle sequence.
